// File: rtl/fft_output_stream.sv
// fft_output_stream: drains FFT result memory LANES samples per beat.
// Optional macro FFT_OUT_BITREV_EN enables bit-reversed read addressing.
module fft_output_stream #(
  parameter int N          = 32,
  parameter int WORD_SIZE  = 16,
  parameter int LANES      = 2,
  parameter int ADDR_WIDTH = $clog2(N)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           bitrev_mode,
  output logic                           rd_en,
  output logic [LANES*ADDR_WIDTH-1:0]    rd_addr,
  input  logic [LANES*2*WORD_SIZE-1:0]   rd_data,
  output logic [LANES*2*WORD_SIZE-1:0]   out_samp,
  output logic [ADDR_WIDTH-1:0]          out_idx,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int DW    = LANES * 2 * WORD_SIZE;
  localparam int BEATS = N / LANES;

  localparam logic [ADDR_WIDTH-1:0] LAST_RB  =
    ADDR_WIDTH'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(N - LANES);
  localparam logic [ADDR_WIDTH-1:0] STEP     =
    ADDR_WIDTH'(LANES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] rb_q;
  logic                  pend_q;
  logic                  done_q;
  logic [DW-1:0]         skid_q;
  logic                  skid_v;
  logic                  pop;
  logic [1:0]            occ;
  logic                  mode;

  assign pop  = out_valid & out_ready;
  assign occ  = {1'b0, out_valid} + {1'b0, skid_v}
              + {1'b0, pend_q};
  assign busy = (state_q != IDLE);
  assign done = done_q;

  assign out_last = out_valid & (out_idx == LAST_IDX);

  assign rd_en = (state_q == RUN)
               & ((occ - {1'b0, pop}) < 2'd2);

`ifdef FFT_OUT_BITREV_EN
  logic mode_q;

  assign mode = mode_q;

  function automatic logic [ADDR_WIDTH-1:0] bitrev(
    input logic [ADDR_WIDTH-1:0] a
  );
    for (int b = 0; b < ADDR_WIDTH; b++)
      bitrev[b] = a[ADDR_WIDTH-1-b];
  endfunction

  // Capture the storage order for the frame being started
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mode_q <= 1'b0;
    else if (state_q == IDLE && start)
      mode_q <= bitrev_mode;
  end
`else
  logic unused_bitrev;

  assign unused_bitrev = bitrev_mode;
  assign mode          = 1'b0;

  function automatic logic [ADDR_WIDTH-1:0] bitrev(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a;
  endfunction
`endif

  // Lane addresses for the current read beat, zero when not reading
  always_comb begin
    rd_addr = '0;
    if (state_q == RUN) begin
      for (int k = 0; k < LANES; k++) begin
        rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] =
          mode ? bitrev(ADDR_WIDTH'(int'(rb_q) * LANES + k))
               : ADDR_WIDTH'(int'(rb_q) * LANES + k);
      end
    end
  end

  // Frame sequencing: read all beats, then wait for last handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (rd_en && rb_q == LAST_RB) state_d = FLUSH;
      FLUSH:   if (pop && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and read beat counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start)
        rb_q <= '0;
      else if (rd_en)
        rb_q <= rb_q + ADDR_WIDTH'(1);
    end
  end

  // Track the read in flight and register the completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pend_q <= rd_en;
      done_q <= (state_q == FLUSH) & pop & out_last;
    end
  end

  // Output register plus skid entry, order preserving
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_samp  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      skid_q    <= '0;
      skid_v    <= 1'b0;
    end else begin
      if (pop)
        out_idx <= out_idx + STEP;
      if (pop) begin
        if (skid_v) begin
          out_samp <= skid_q;
          skid_v   <= pend_q;
          if (pend_q)
            skid_q <= rd_data;
        end else begin
          out_valid <= pend_q;
          if (pend_q)
            out_samp <= rd_data;
        end
      end else if (pend_q) begin
        if (out_valid) begin
          skid_q <= rd_data;
          skid_v <= 1'b1;
        end else begin
          out_samp  <= rd_data;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_output_stream.sv
// tb_fft_output_stream: directed frames against a beat-level model.
// Expectations follow FFT_OUT_BITREV_EN when it is defined.
module tb_fft_output_stream;

  localparam int N  = 32;
  localparam int WS = 16;
  localparam int L  = 2;
  localparam int AW = 5;
  localparam int NB = N / L;
  localparam int DW = L * 2 * WS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          bitrev_mode = 1'b0;
  logic          rd_en;
  logic [L*AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] out_samp;
  logic [AW-1:0] out_idx;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  bit bp = 0;

  always #5 clk = ~clk;

  fft_output_stream #(
    .N(N), .WORD_SIZE(WS), .LANES(L), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bitrev_mode(bitrev_mode),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out_samp(out_samp),
    .out_idx(out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  function automatic logic [31:0] word(input int a);
    return {16'(a), 16'(16'hFFFF - a)};
  endfunction

  function automatic int brev(input int i);
    int r;
    r = 0;
    for (int b = 0; b < AW; b++)
      r = r * 2 + ((i >> b) & 1);
    return r;
  endfunction

  function automatic int eaddr(input int i, input bit m);
    return m ? brev(i) : i;
  endfunction

  function automatic logic [DW-1:0] ebeat(input int b, input bit m);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < L; k++)
      v[k*32 +: 32] = word(eaddr(b * L + k, m));
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // memory: data for the addresses presented with rd_en, next cycle
  always @(posedge clk) begin
    for (int k = 0; k < L; k++)
      rd_data[k*32 +: 32] <= rd_en
        ? word(int'(rd_addr[k*AW +: AW])) : 32'hDEADBEEF;
  end

  // beat-level model state
  bit m_busy = 0;
  bit m_mode = 0;
  bit m_lastp = 0;
  bit m_stall = 0;
  bit h1 = 0;
  bit h2 = 0;
  int rc = 0;
  int ac = 0;
  int ret = 0;
  bit m_pop;
  bit m_rd;
  int m_occ;

  // compare process: checks every cycle against the model
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        m_busy = 0; m_mode = 0; m_lastp = 0; m_stall = 0;
        h1 = 0; h2 = 0; rc = 0; ac = 0; ret = 0;
      end else begin
        ret += int'(h2);
        m_pop = out_valid && out_ready;
        chk("done", done, m_lastp);
        chk("busy", busy, m_busy);
        chk("out_valid", out_valid, ret > ac);
        if (m_stall)
          chk("stall_hold", out_valid, 1);
        m_occ = rc - ac;
        m_rd = m_busy && rc < NB && (m_occ - int'(m_pop)) < 2;
        chk("rd_en", rd_en, m_rd);
        if (rd_en)
          for (int k = 0; k < L; k++)
            chk("rd_addr", rd_addr[k*AW +: AW],
                eaddr(rc * L + k, m_mode));
        if (out_valid) begin
          chk("out_samp", out_samp, ebeat(ac, m_mode));
          chk("out_idx", out_idx, ac * L);
          chk("out_last", out_last, ac == NB - 1);
        end else begin
          chk("out_last_idle", out_last, 0);
        end
        m_lastp = m_pop && ac == NB - 1;
        m_stall = out_valid && !out_ready;
        h2 = h1;
        h1 = rd_en;
        if (rd_en) rc++;
        if (m_pop) ac++;
        if (m_lastp) begin
          m_busy = 0;
        end else if (!m_busy && start) begin
          m_busy = 1;
          rc = 0; ac = 0; ret = 0;
`ifdef FFT_OUT_BITREV_EN
          m_mode = bitrev_mode;
`else
          m_mode = 0;
`endif
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic pulse_start(input logic m);
    cyc();
    start = 1'b1;
    bitrev_mode = m;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_last(input string nm);
    for (int n = 0; n < 400; n++) begin
      cyc();
      #2;
      if (out_valid && out_ready && out_last) begin
        checks++;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: last beat not seen within 400 cycles", nm);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd_en"}, rd_en, 0);
    chk({nm, "_rd_addr"}, rd_addr, 0);
    chk({nm, "_out_samp"}, out_samp, 0);
    chk({nm, "_out_idx"}, out_idx, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_last"}, out_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal;
  end

  int run;
  int n;

  initial begin
    repeat (3) cyc();
    #2;
    chk_zero("reset");
    cyc();
    reset = 1'b0;
    cyc();

    // natural order, out_ready high, latency and run length
    cyc();
    start = 1'b1;
    bitrev_mode = 1'b0;
    cyc();
    start = 1'b0;
    #2;
    chk("lat_busy", busy, 1);
    chk("lat_rd_en", rd_en, 1);
    chk("lat_addr0", rd_addr, 10'h020);
    chk("lat_v_e0", out_valid, 0);
    cyc(); #2;
    chk("lat_v_e1", out_valid, 0);
    cyc(); #2;
    chk("lat_v_e2", out_valid, 1);
    chk("beat0_nat", out_samp, 64'h0001FFFE_0000FFFF);
    run = 0;
    while (out_valid && run < 40) begin
      run++;
      if (run == 16) begin
        chk("last_idx", out_idx, 30);
        chk("last_flag", out_last, 1);
      end
      cyc(); #2;
    end
    chk("run_len", run, 16);
    chk("done_pulse", done, 1);
    cyc(); #2;
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);

    // bitrev_mode=1, out_ready high
    pulse_start(1'b1);
    #2;
`ifdef FFT_OUT_BITREV_EN
    chk("br_addr0", rd_addr, 10'h200);
`else
    chk("br_addr0", rd_addr, 10'h020);
`endif
    cyc(); #2;
`ifdef FFT_OUT_BITREV_EN
    chk("br_addr1", rd_addr, 10'h308);
`else
    chk("br_addr1", rd_addr, 10'h062);
`endif
    cyc(); #2;
`ifdef FFT_OUT_BITREV_EN
    chk("br_beat0", out_samp, 64'h0010FFEF_0000FFFF);
`else
    chk("br_beat0", out_samp, 64'h0001FFFE_0000FFFF);
`endif
    cyc(); #2;
`ifdef FFT_OUT_BITREV_EN
    chk("br_beat1", out_samp, 64'h0018FFE7_0008FFF7);
`else
    chk("br_beat1", out_samp, 64'h0003FFFC_0002FFFD);
`endif
    wait_last("br_frame");
    cyc(); #2;
    chk("br_done", done, 1);

    // backpressure, mid-frame start, back-to-back start in done cycle
    bp = 1;
    pulse_start(1'b0);
    repeat (10) cyc();
    start = 1'b1;
    bitrev_mode = 1'b1;
    cyc();
    start = 1'b0;
    wait_last("bp_frame0");
    cyc();
    start = 1'b1;
    bitrev_mode = 1'b1;
    #2;
    chk("bp_done0", done, 1);
    cyc();
    start = 1'b0;
    #2;
    chk("b2b_busy", busy, 1);
    wait_last("bp_frame1");
    cyc(); #2;
    chk("bp_done1", done, 1);
    bp = 0;
    cyc();

    // asynchronous reset while beat 7 is presented
    pulse_start(1'b0);
    n = 0;
    #2;
    while (!(out_valid && out_idx == 5'd14) && n < 60) begin
      n++;
      cyc(); #2;
    end
    chk("beat7_seen", out_idx, 14);
    #1;
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    pulse_start(1'b0);
    wait_last("post_reset");
    cyc(); #2;
    chk("post_reset_done", done, 1);

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
